// File: rtl/adc_capture_skin_if.sv
// Snapshot handshake bundle for adc_capture_skin.
// Master is the capture block; slave is the consumer.
interface adc_capture_skin_if #(
    parameter int NCH   = 4,
    parameter int DW    = 16,
    parameter int CNT_W = 32
);
    logic                snap_req;
    logic                snap_ack;
    logic                snap_valid;
    logic [NCH*DW-1:0]   snap_data;
    logic [CNT_W-1:0]    snap_count;

    modport master (
        input  snap_req,
        input  snap_ack,
        output snap_valid,
        output snap_data,
        output snap_count
    );

    modport slave (
        output snap_req,
        output snap_ack,
        input  snap_valid,
        input  snap_data,
        input  snap_count
    );
endinterface

// File: rtl/adc_capture_skin.sv
// N-channel ADC capture: input pipeline, channel masking,
// stuck-bit activity monitor and a held snapshot with req/ack.
module adc_capture_skin #(
    parameter int NCH      = 4,
    parameter int DW       = 16,
    parameter int STAGES   = 2,
    parameter int WIN_LOG2 = 16,
    parameter int CNT_W    = 32
) (
    input  logic                clk_adc,
    input  logic                clk_adc_reset_n,
    input  logic [NCH*DW-1:0]   adc_data,
    input  logic [NCH-1:0]      ch_enable,
    output logic [NCH*DW-1:0]   data_out,
    output logic                data_valid,
    output logic [CNT_W-1:0]    sample_count,
    output logic [NCH*DW-1:0]   toggle_mask,
    output logic                win_done,
    adc_capture_skin_if.master  snap
);
    localparam int W  = NCH * DW;
    localparam int FW = (STAGES > 1) ? $clog2(STAGES) : 1;

    logic [W-1:0] en_mask;

    for (genvar c = 0; c < NCH; c++) begin : g_mask
        assign en_mask[c*DW +: DW] = {DW{ch_enable[c]}};
    end

    (* magic_cdc *) logic [W-1:0] s0_q;
    logic [W-1:0] chain [STAGES];

    always_ff @(posedge clk_adc or negedge clk_adc_reset_n) begin
        if (!clk_adc_reset_n)
            s0_q <= '0;
        else if (STAGES == 1)
            s0_q <= adc_data & en_mask;
        else
            s0_q <= adc_data;
    end

    assign chain[0] = s0_q;

    // Only the last stage applies the mask so enables act with one edge.
    for (genvar g = 1; g < STAGES; g++) begin : g_stg
        logic [W-1:0] q;
        always_ff @(posedge clk_adc or negedge clk_adc_reset_n) begin
            if (!clk_adc_reset_n)
                q <= '0;
            else if (g == STAGES - 1)
                q <= chain[g-1] & en_mask;
            else
                q <= chain[g-1];
        end
        assign chain[g] = q;
    end

    assign data_out = chain[STAGES-1];

    logic [FW-1:0] fill_q;

    always_ff @(posedge clk_adc or negedge clk_adc_reset_n) begin
        if (!clk_adc_reset_n) begin
            fill_q     <= '0;
            data_valid <= 1'b0;
        end else if (!data_valid) begin
            if (fill_q == FW'(STAGES - 1))
                data_valid <= 1'b1;
            else
                fill_q <= fill_q + 1'b1;
        end
    end

    always_ff @(posedge clk_adc or negedge clk_adc_reset_n) begin
        if (!clk_adc_reset_n)
            sample_count <= '0;
        else if (data_valid)
            sample_count <= sample_count + 1'b1;
    end

    logic [W-1:0]        prev_q;
    logic [W-1:0]        acc_q;
    logic [WIN_LOG2-1:0] win_cnt_q;
    logic [W-1:0]        diff;

    assign diff = data_out ^ prev_q;

    always_ff @(posedge clk_adc or negedge clk_adc_reset_n) begin
        if (!clk_adc_reset_n) begin
            prev_q      <= '0;
            acc_q       <= '0;
            win_cnt_q   <= '0;
            toggle_mask <= '0;
            win_done    <= 1'b0;
        end else begin
            win_done <= 1'b0;
            if (data_valid) begin
                prev_q    <= data_out;
                win_cnt_q <= win_cnt_q + 1'b1;
                if (&win_cnt_q) begin
                    toggle_mask <= acc_q | diff;
                    acc_q       <= '0;
                    win_done    <= 1'b1;
                end else begin
                    acc_q <= acc_q | diff;
                end
            end
        end
    end

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    state_t state_q;

    always_ff @(posedge clk_adc or negedge clk_adc_reset_n) begin
        if (!clk_adc_reset_n) begin
            state_q         <= S_IDLE;
            snap.snap_valid <= 1'b0;
            snap.snap_data  <= '0;
            snap.snap_count <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (snap.snap_req && data_valid) begin
                        snap.snap_data  <= data_out;
                        snap.snap_count <= sample_count;
                        snap.snap_valid <= 1'b1;
                        state_q         <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // An ack wins over a coincident req; the req is dropped.
                    if (snap.snap_ack) begin
                        snap.snap_valid <= 1'b0;
                        state_q         <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adc_capture_skin.sv
// Directed bench for adc_capture_skin with a queue-based
// reference model checked on every cycle.
module tb_adc_capture_skin;
  localparam int NCH = 4;
  localparam int DW = 16;
  localparam int STG = 2;
  localparam int WL2 = 4;
  localparam int CW = 8;
  localparam int WIN = 1 << WL2;

  logic clk = 1'b0;
  logic rst_n;
  logic [63:0] adc;
  logic [3:0] en;
  logic [63:0] dout;
  logic dv;
  logic [7:0] cnt;
  logic [63:0] tmask;
  logic wdone;

  int nchk = 0;
  int nbad = 0;

  adc_capture_skin_if #(.NCH(NCH), .DW(DW), .CNT_W(CW)) sif ();

  adc_capture_skin #(
    .NCH(NCH), .DW(DW), .STAGES(STG),
    .WIN_LOG2(WL2), .CNT_W(CW)
  ) dut (
    .clk_adc(clk),
    .clk_adc_reset_n(rst_n),
    .adc_data(adc),
    .ch_enable(en),
    .data_out(dout),
    .data_valid(dv),
    .sample_count(cnt),
    .toggle_mask(tmask),
    .win_done(wdone),
    .snap(sif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // reference model state
  int k;
  logic [63:0] hist[$];
  logic [63:0] vq[$];
  logic [63:0] e_dout, e_tm, e_sd;
  logic [7:0] e_cnt, e_sc;
  bit e_dv, e_wd, m_hold;

  function automatic logic [63:0] expand(input logic [3:0] e);
    logic [63:0] m;
    for (int c = 0; c < NCH; c++)
      m[c*DW +: DW] = {DW{e[c]}};
    return m;
  endfunction

  task automatic model_reset();
    k = 0;
    hist.delete();
    for (int i = 0; i < STG; i++) hist.push_back(64'h0);
    vq.delete();
    e_dout = 0; e_tm = 0; e_sd = 0;
    e_cnt = 0; e_sc = 0;
    e_dv = 0; e_wd = 0; m_hold = 0;
  endtask

  task automatic model_step();
    logic [63:0] od, m, pv;
    logic [7:0] oc;
    bit ov;
    int v;
    od = e_dout; ov = e_dv; oc = e_cnt;
    if (!m_hold) begin
      if (sif.snap_req && ov) begin
        m_hold = 1; e_sd = od; e_sc = oc;
      end
    end else if (sif.snap_ack) begin
      m_hold = 0;
    end
    e_wd = 0;
    if (ov) begin
      vq.push_back(od);
      v = vq.size() - 1;
      if (v % WIN == WIN - 1) begin
        m = 0;
        for (int u = v - WIN + 1; u <= v; u++) begin
          pv = (u == 0) ? 64'h0 : vq[u-1];
          m |= vq[u] ^ pv;
        end
        e_tm = m;
        e_wd = 1;
      end
    end
    hist.push_back(adc);
    void'(hist.pop_front());
    e_dout = hist[0] & expand(en);
    k++;
    e_dv = (k >= STG);
    e_cnt = e_dv ? 8'(k - STG) : 8'h0;
  endtask

  initial begin : model_proc
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin : compare_proc
    forever begin
      @(negedge clk);
      chk("data_out", dout, e_dout);
      chk("data_valid", 64'(dv), 64'(e_dv));
      chk("sample_count", 64'(cnt), 64'(e_cnt));
      chk("toggle_mask", tmask, e_tm);
      chk("win_done", 64'(wdone), 64'(e_wd));
      chk("snap_valid", 64'(sif.snap_valid), 64'(m_hold));
      chk("snap_data", sif.snap_data, e_sd);
      chk("snap_count", 64'(sif.snap_count), 64'(e_sc));
    end
  end

  initial begin : stim
    int pulses;
    bit hit;
    rst_n = 1'b0;
    adc = 0;
    en = 4'hF;
    sif.snap_req = 1'b0;
    sif.snap_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst dv", 64'(dv), 64'h0);
    chk("rst dout", dout, 64'h0);
    chk("rst snap_valid", 64'(sif.snap_valid), 64'h0);

    // release, with a req before data is valid
    rst_n = 1'b1;
    sif.snap_req = 1'b1;
    @(negedge clk);
    chk("fill dv e1", 64'(dv), 64'h0);
    @(negedge clk);
    chk("fill dv e2", 64'(dv), 64'h1);
    chk("first cnt", 64'(cnt), 64'h0);
    sif.snap_req = 1'b0;
    @(negedge clk);
    chk("early req ign", 64'(sif.snap_valid), 64'h0);

    // latency
    adc = 64'h0000_0000_0000_1234;
    @(negedge clk);
    @(negedge clk);
    chk("lat ch0", 64'(dout[15:0]), 64'h1234);

    // masking
    adc = 64'h4444_3333_2222_1234;
    repeat (2) @(negedge clk);
    chk("all en", dout, 64'h4444_3333_2222_1234);
    en = 4'b1011;
    @(negedge clk);
    chk("mask ch2", dout, 64'h4444_0000_2222_1234);

    // activity window
    pulses = 0;
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      if (wdone) pulses++;
      if (pulses == 3) begin
        hit = 1;
        break;
      end
      adc = {48'h4444_3333_2222, 16'h8000 | 16'(i & 1)};
      @(negedge clk);
    end
    chk("win found", 64'(hit), 64'h1);
    chk("win tmask", tmask, 64'h0000_0000_0000_0001);

    // snapshot at sample_count=100
    adc = 64'hCAFE_BEEF_0F0F_1234;
    hit = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (i >= 2 && cnt == 8'd100) begin
        hit = 1;
        break;
      end
    end
    chk("cnt 100 found", 64'(hit), 64'h1);
    sif.snap_req = 1'b1;
    @(negedge clk);
    sif.snap_req = 1'b0;
    adc = 64'h1111_2222_3333_4444;
    chk("snap valid", 64'(sif.snap_valid), 64'h1);
    chk("snap cnt", 64'(sif.snap_count), 64'd100);
    chk("snap data", sif.snap_data, 64'hCAFE_0000_0F0F_1234);
    repeat (4) @(negedge clk);
    sif.snap_req = 1'b1;
    @(negedge clk);
    sif.snap_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("hold data", sif.snap_data, 64'hCAFE_0000_0F0F_1234);
    chk("hold cnt", 64'(sif.snap_count), 64'd100);
    chk("hold valid", 64'(sif.snap_valid), 64'h1);
    sif.snap_ack = 1'b1;
    @(negedge clk);
    sif.snap_ack = 1'b0;
    chk("ack drop", 64'(sif.snap_valid), 64'h0);

    // req+ack together in HOLD
    sif.snap_req = 1'b1;
    @(negedge clk);
    chk("recap", 64'(sif.snap_valid), 64'h1);
    sif.snap_ack = 1'b1;
    @(negedge clk);
    chk("req+ack", 64'(sif.snap_valid), 64'h0);
    sif.snap_req = 1'b0;
    sif.snap_ack = 1'b0;
    @(negedge clk);
    chk("no recap", 64'(sif.snap_valid), 64'h0);
    sif.snap_ack = 1'b1;
    @(negedge clk);
    sif.snap_ack = 1'b0;
    chk("idle ack", 64'(sif.snap_valid), 64'h0);

    // counter wrap
    hit = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cnt == 8'hFF) begin
        hit = 1;
        break;
      end
    end
    chk("cnt ff found", 64'(hit), 64'h1);
    @(negedge clk);
    chk("cnt wrap", 64'(cnt), 64'h0);

    // async reset mid-HOLD
    sif.snap_req = 1'b1;
    @(negedge clk);
    sif.snap_req = 1'b0;
    chk("pre-rst hold", 64'(sif.snap_valid), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async sv", 64'(sif.snap_valid), 64'h0);
    chk("async dv", 64'(dv), 64'h0);
    chk("async dout", dout, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post-rst dv", 64'(dv), 64'h1);

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
endmodule
